dcache_axi_if: RTL and testbench
================================

DCACHE_AXI_IF -- requirements
Module: dcache_axi_if

Interface
REQ-001 SHALL have parameter AXI_ID, default 4'd1: ID driven on arid and awid.
REQ-002 SHALL have parameter LINE_BEATS, default 8: words per cache line (fixed at 8, 256-bit line).
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 ca_rreq_i  input  1  cached line-refill request (one-cycle pulse, sampled only when read FSM is R_IDLE).
REQ-006 uc_rreq_i  input  1  uncached single-word read request.
REQ-007 uc_wreq_i  input  1  uncached single-word write request.
REQ-008 wb_req_i  input  1  dirty-line writeback request.
REQ-009 raddr_i  input  32  physical read address.
REQ-010 waddr_i  input  32  physical write address.
REQ-011 uc_size_i  input  2  access size for uncached read or write (0 byte, 1 half, 2 word).
REQ-012 uc_wdata_i / uc_wstrb_i  input  32 / 4  uncached write data and byte strobes.
REQ-013 wb_line_i  input  256  writeback line, word i in bits [32i+31:32i].
REQ-014 rend_o  output  1  one-cycle pulse: read response complete, data valid this cycle.
REQ-015 line_rdata_o  output  256  refilled line (uncached read: word in [31:0], upper bits zero).
REQ-016 wend_o  output  1  one-cycle pulse: write response received.
REQ-017 rbusy_o / wbusy_o  output  1 / 1  read FSM / write FSM not idle.
REQ-018 arid, araddr, arlen, arsize, arburst, arvalid  output  4,32,8,3,2,1  AXI read address channel; arready input 1.
REQ-019 rid, rdata, rresp, rlast, rvalid  input  4,32,2,1,1  AXI read data channel; rready output 1.
REQ-020 awid, awaddr, awlen, awsize, awburst, awvalid  output  4,32,8,3,2,1  AXI write address channel; awready input 1.
REQ-021 wdata, wstrb, wlast, wvalid  output  32,4,1,1  AXI write data channel; wready input 1.
REQ-022 bvalid, bresp  input  1,2  AXI write response; bready output 1.

Function
REQ-023 Read FSM SHALL have states R_IDLE, R_AR, R_DATA; transitions R_IDLE->R_AR on (ca_rreq_i|uc_rreq_i), R_AR->R_DATA on arvalid&arready, R_DATA->R_IDLE on rvalid&rready&rlast.
REQ-024 If ca_rreq_i and uc_rreq_i are both high, refill SHALL win; request type, address, size latched on R_IDLE exit; inputs ignored while not R_IDLE.
REQ-025 Refill: araddr = {raddr[31:5],5'b0}, arlen=7, arsize=2, arburst=INCR; uncached: araddr=raddr_i, arlen=0, arsize={1'b0,uc_size}, arburst=INCR.
REQ-026 arvalid SHALL be high exactly in R_AR and held until arready; rready high exactly in R_DATA.
REQ-027 A 3-bit beat counter SHALL reset to 0 on R_AR->R_DATA, store rdata into word[counter] on each rvalid&rready, increment (wrap 7->0).
REQ-028 rend_o SHALL pulse in the cycle after the rlast handshake, line_rdata_o complete that cycle and held until the next read request is latched; rresp ignored.
REQ-029 Write FSM SHALL have states W_IDLE, W_AW, W_DATA, W_B; W_IDLE->W_AW on (wb_req_i|uc_wreq_i), W_AW->W_DATA on awready, W_DATA->W_B on wvalid&wready&wlast, W_B->W_IDLE on bvalid&bready.
REQ-030 Writeback SHALL win over uncached write; writeback: awaddr={waddr[31:5],5'b0}, awlen=7, awsize=2, wstrb=4'hF, wdata=word[beat], wlast at beat 7; uncached: awaddr=waddr_i, awlen=0, wstrb=uc_wstrb_i, wlast=1.
REQ-031 Write data and line SHALL be latched on W_IDLE exit; wvalid only in W_DATA; bready only in W_B; wend_o pulses the cycle after bvalid&bready.
REQ-032 Read and write FSMs SHALL run independently and concurrently; a read and write request in the same cycle are both accepted.
REQ-033 rid/bresp mismatch SHALL not alter behaviour.

Reset
REQ-034 On rst_n low, SHALL asynchronously force R_IDLE, W_IDLE, counters 0, all valid/ready outputs 0, rend_o=wend_o=0, line_rdata_o=0, busy outputs 0; any in-flight transaction is abandoned.

Verification
REQ-035 Refill raddr=0x1F00_0024, arready after 2 cycles, 8 beats 0..7 -> araddr=0x1F00_0020, arlen=7, line_rdata_o word i = i, rend_o one pulse.
REQ-036 Uncached read uc_size=1, rdata=0xBEEF -> arlen=0, arsize=1, line_rdata_o[31:0]=0xBEEF, rend_o pulse.
REQ-037 Writeback with wready toggling every other cycle -> 8 W beats in order, wlast only on 8th, wend_o one cycle after bvalid.
REQ-038 ca_rreq_i and uc_rreq_i together plus wb_req_i same cycle -> refill and writeback both issued concurrently, uncached read dropped.
REQ-039 rst_n asserted in R_DATA beat 3 -> all outputs 0 immediately, new request after release completes normally.

Source files
------------

// File: rtl/dcache_axi_if_if.sv
// AXI4 bus between the data-cache refill/writeback engine (master) and memory (slave).
interface dcache_axi_bus_if;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        arvalid;
  logic        arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;
  logic [3:0]  awid;
  logic [31:0] awaddr;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;
  logic        wvalid;
  logic        wready;
  logic        bvalid;
  logic [1:0]  bresp;
  logic        bready;

  modport master (
    output arid, araddr, arlen, arsize, arburst, arvalid, input arready,
    input rid, rdata, rresp, rlast, rvalid, output rready,
    output awid, awaddr, awlen, awsize, awburst, awvalid, input awready,
    output wdata, wstrb, wlast, wvalid, input wready,
    input bvalid, bresp, output bready
  );

  modport slave (
    input arid, araddr, arlen, arsize, arburst, arvalid, output arready,
    output rid, rdata, rresp, rlast, rvalid, input rready,
    input awid, awaddr, awlen, awsize, awburst, awvalid, output awready,
    input wdata, wstrb, wlast, wvalid, output wready,
    output bvalid, bresp, input bready
  );
endinterface

// File: rtl/dcache_axi_if.sv
// Data-cache AXI master: independent read FSM (line refill / uncached read) and
// write FSM (line writeback / uncached write), all bus outputs registered.
module dcache_axi_if #(
  parameter logic [3:0] AXI_ID     = 4'd1,
  parameter int         LINE_BEATS = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         ca_rreq_i,
  input  logic         uc_rreq_i,
  input  logic         uc_wreq_i,
  input  logic         wb_req_i,
  input  logic [31:0]  raddr_i,
  input  logic [31:0]  waddr_i,
  input  logic [1:0]   uc_size_i,
  input  logic [31:0]  uc_wdata_i,
  input  logic [3:0]   uc_wstrb_i,
  input  logic [255:0] wb_line_i,
  output logic         rend_o,
  output logic [255:0] line_rdata_o,
  output logic         wend_o,
  output logic         rbusy_o,
  output logic         wbusy_o,
  dcache_axi_bus_if.master axi
);

  localparam logic [7:0] BURST_LEN = 8'(LINE_BEATS - 1);
  localparam logic [1:0] BURST_INCR = 2'b01;

  typedef enum logic [1:0] {R_IDLE = 2'd0, R_AR = 2'd1, R_DATA = 2'd2} rstate_t;
  typedef enum logic [1:0] {W_IDLE = 2'd0, W_AW = 2'd1, W_DATA = 2'd2, W_B = 2'd3} wstate_t;

  rstate_t      rstate_q, rstate_d;
  logic         arvalid_q, arvalid_d;
  logic [31:0]  araddr_q, araddr_d;
  logic [7:0]   arlen_q, arlen_d;
  logic [2:0]   arsize_q, arsize_d;
  logic         rready_q, rready_d;
  logic [2:0]   rcnt_q, rcnt_d;
  logic [255:0] line_q, line_d;
  logic         rend_q, rend_d;
  logic         rbusy_q, rbusy_d;

  wstate_t      wstate_q, wstate_d;
  logic         awvalid_q, awvalid_d;
  logic [31:0]  awaddr_q, awaddr_d;
  logic [7:0]   awlen_q, awlen_d;
  logic [2:0]   awsize_q, awsize_d;
  logic [255:0] wline_q, wline_d;
  logic [3:0]   wstrb_q, wstrb_d;
  logic [31:0]  wdata_q, wdata_d;
  logic         wlast_q, wlast_d;
  logic         wvalid_q, wvalid_d;
  logic         bready_q, bready_d;
  logic [2:0]   wbeat_q, wbeat_d;
  logic         wend_q, wend_d;
  logic         wbusy_q, wbusy_d;

  logic [2:0]   wbeat_nx_s;
  logic         unused_s;

  assign wbeat_nx_s = wbeat_q + 3'd1;
  // Response ID and status are deliberately ignored.
  assign unused_s   = ^{axi.rid, axi.rresp, axi.bresp};

  // Read FSM next-state and registered-output computation.
  always_comb begin
    rstate_d  = rstate_q;
    arvalid_d = arvalid_q;
    araddr_d  = araddr_q;
    arlen_d   = arlen_q;
    arsize_d  = arsize_q;
    rready_d  = rready_q;
    rcnt_d    = rcnt_q;
    line_d    = line_q;
    rend_d    = 1'b0;
    case (rstate_q)
      R_IDLE: begin
        if (ca_rreq_i || uc_rreq_i) begin
          if (ca_rreq_i) begin
            araddr_d = {raddr_i[31:5], 5'd0};
            arlen_d  = BURST_LEN;
            arsize_d = 3'd2;
          end else begin
            araddr_d = raddr_i;
            arlen_d  = 8'd0;
            arsize_d = {1'b0, uc_size_i};
          end
          line_d    = 256'd0;
          arvalid_d = 1'b1;
          rstate_d  = R_AR;
        end else begin
          rstate_d = R_IDLE;
        end
      end
      R_AR: begin
        if (axi.arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          rcnt_d    = 3'd0;
          rstate_d  = R_DATA;
        end else begin
          arvalid_d = 1'b1;
        end
      end
      R_DATA: begin
        if (axi.rvalid && rready_q) begin
          line_d[{rcnt_q, 5'd0} +: 32] = axi.rdata;
          rcnt_d = rcnt_q + 3'd1;
          if (axi.rlast) begin
            rready_d = 1'b0;
            rend_d   = 1'b1;
            rstate_d = R_IDLE;
          end else begin
            rstate_d = R_DATA;
          end
        end else begin
          rstate_d = R_DATA;
        end
      end
      default: begin
        rstate_d  = R_IDLE;
        arvalid_d = 1'b0;
        rready_d  = 1'b0;
      end
    endcase
    rbusy_d = (rstate_d != R_IDLE);
  end

  // Read FSM state and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rstate_q  <= R_IDLE;
      arvalid_q <= 1'b0;
      araddr_q  <= 32'd0;
      arlen_q   <= 8'd0;
      arsize_q  <= 3'd0;
      rready_q  <= 1'b0;
      rcnt_q    <= 3'd0;
      line_q    <= 256'd0;
      rend_q    <= 1'b0;
      rbusy_q   <= 1'b0;
    end else begin
      rstate_q  <= rstate_d;
      arvalid_q <= arvalid_d;
      araddr_q  <= araddr_d;
      arlen_q   <= arlen_d;
      arsize_q  <= arsize_d;
      rready_q  <= rready_d;
      rcnt_q    <= rcnt_d;
      line_q    <= line_d;
      rend_q    <= rend_d;
      rbusy_q   <= rbusy_d;
    end
  end

  // Write FSM next-state and registered-output computation.
  always_comb begin
    wstate_d  = wstate_q;
    awvalid_d = awvalid_q;
    awaddr_d  = awaddr_q;
    awlen_d   = awlen_q;
    awsize_d  = awsize_q;
    wline_d   = wline_q;
    wstrb_d   = wstrb_q;
    wdata_d   = wdata_q;
    wlast_d   = wlast_q;
    wvalid_d  = wvalid_q;
    bready_d  = bready_q;
    wbeat_d   = wbeat_q;
    wend_d    = 1'b0;
    case (wstate_q)
      W_IDLE: begin
        if (wb_req_i || uc_wreq_i) begin
          if (wb_req_i) begin
            awaddr_d = {waddr_i[31:5], 5'd0};
            awlen_d  = BURST_LEN;
            awsize_d = 3'd2;
            wline_d  = wb_line_i;
            wstrb_d  = 4'hF;
          end else begin
            awaddr_d = waddr_i;
            awlen_d  = 8'd0;
            awsize_d = {1'b0, uc_size_i};
            wline_d  = {224'd0, uc_wdata_i};
            wstrb_d  = uc_wstrb_i;
          end
          awvalid_d = 1'b1;
          wstate_d  = W_AW;
        end else begin
          wstate_d = W_IDLE;
        end
      end
      W_AW: begin
        if (axi.awready) begin
          awvalid_d = 1'b0;
          wvalid_d  = 1'b1;
          wbeat_d   = 3'd0;
          wdata_d   = wline_q[31:0];
          wlast_d   = (awlen_q == 8'd0);
          wstate_d  = W_DATA;
        end else begin
          awvalid_d = 1'b1;
        end
      end
      W_DATA: begin
        if (axi.wready && wvalid_q) begin
          if (wlast_q) begin
            wvalid_d = 1'b0;
            wlast_d  = 1'b0;
            bready_d = 1'b1;
            wstate_d = W_B;
          end else begin
            // Prefetch the next beat so wdata/wlast stay registered.
            wbeat_d = wbeat_nx_s;
            wdata_d = wline_q[{wbeat_nx_s, 5'd0} +: 32];
            wlast_d = ({5'd0, wbeat_nx_s} == awlen_q);
          end
        end else begin
          wstate_d = W_DATA;
        end
      end
      W_B: begin
        if (axi.bvalid && bready_q) begin
          bready_d = 1'b0;
          wend_d   = 1'b1;
          wstate_d = W_IDLE;
        end else begin
          wstate_d = W_B;
        end
      end
      default: begin
        wstate_d  = W_IDLE;
        awvalid_d = 1'b0;
        wvalid_d  = 1'b0;
        bready_d  = 1'b0;
      end
    endcase
    wbusy_d = (wstate_d != W_IDLE);
  end

  // Write FSM state and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wstate_q  <= W_IDLE;
      awvalid_q <= 1'b0;
      awaddr_q  <= 32'd0;
      awlen_q   <= 8'd0;
      awsize_q  <= 3'd0;
      wline_q   <= 256'd0;
      wstrb_q   <= 4'd0;
      wdata_q   <= 32'd0;
      wlast_q   <= 1'b0;
      wvalid_q  <= 1'b0;
      bready_q  <= 1'b0;
      wbeat_q   <= 3'd0;
      wend_q    <= 1'b0;
      wbusy_q   <= 1'b0;
    end else begin
      wstate_q  <= wstate_d;
      awvalid_q <= awvalid_d;
      awaddr_q  <= awaddr_d;
      awlen_q   <= awlen_d;
      awsize_q  <= awsize_d;
      wline_q   <= wline_d;
      wstrb_q   <= wstrb_d;
      wdata_q   <= wdata_d;
      wlast_q   <= wlast_d;
      wvalid_q  <= wvalid_d;
      bready_q  <= bready_d;
      wbeat_q   <= wbeat_d;
      wend_q    <= wend_d;
      wbusy_q   <= wbusy_d;
    end
  end

  assign axi.arid    = AXI_ID;
  assign axi.araddr  = araddr_q;
  assign axi.arlen   = arlen_q;
  assign axi.arsize  = arsize_q;
  assign axi.arburst = BURST_INCR;
  assign axi.arvalid = arvalid_q;
  assign axi.rready  = rready_q;
  assign axi.awid    = AXI_ID;
  assign axi.awaddr  = awaddr_q;
  assign axi.awlen   = awlen_q;
  assign axi.awsize  = awsize_q;
  assign axi.awburst = BURST_INCR;
  assign axi.awvalid = awvalid_q;
  assign axi.wdata   = wdata_q;
  assign axi.wstrb   = wstrb_q;
  assign axi.wlast   = wlast_q;
  assign axi.wvalid  = wvalid_q;
  assign axi.bready  = bready_q;

  assign rend_o       = rend_q;
  assign line_rdata_o = line_q;
  assign wend_o       = wend_q;
  assign rbusy_o      = rbusy_q;
  assign wbusy_o      = wbusy_q;

endmodule

// File: tb/tb_dcache_axi_if.sv
// Self-checking bench for dcache_axi_if: vector tables drive an AXI slave model,
// read lines and write beats are checked against scoreboard queues.
module tb_dcache_axi_if;

  logic         clk;
  logic         rst_n;
  logic         ca_rreq_i, uc_rreq_i, uc_wreq_i, wb_req_i;
  logic [31:0]  raddr_i, waddr_i;
  logic [1:0]   uc_size_i;
  logic [31:0]  uc_wdata_i;
  logic [3:0]   uc_wstrb_i;
  logic [255:0] wb_line_i;
  logic         rend_o, wend_o, rbusy_o, wbusy_o;
  logic [255:0] line_rdata_o;

  dcache_axi_bus_if bus ();

  dcache_axi_if #(.AXI_ID(4'd1), .LINE_BEATS(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .ca_rreq_i(ca_rreq_i), .uc_rreq_i(uc_rreq_i), .uc_wreq_i(uc_wreq_i), .wb_req_i(wb_req_i),
    .raddr_i(raddr_i), .waddr_i(waddr_i), .uc_size_i(uc_size_i),
    .uc_wdata_i(uc_wdata_i), .uc_wstrb_i(uc_wstrb_i), .wb_line_i(wb_line_i),
    .rend_o(rend_o), .line_rdata_o(line_rdata_o), .wend_o(wend_o),
    .rbusy_o(rbusy_o), .wbusy_o(wbusy_o), .axi(bus.master)
  );

  typedef struct {
    bit ca; bit uc; logic [31:0] addr; logic [1:0] size; int ar_dly; logic [31:0] base;
    logic [31:0] e_araddr; logic [7:0] e_arlen; logic [2:0] e_arsize;
  } rd_vec_t;

  typedef struct {
    bit wb; bit uc; logic [31:0] addr; logic [1:0] size; logic [31:0] data; logic [3:0] strb;
    bit toggle; logic [31:0] e_awaddr; logic [7:0] e_awlen; logic [2:0] e_awsize;
  } wr_vec_t;

  typedef struct { logic [31:0] d; logic [3:0] s; logic l; } wbeat_t;

  rd_vec_t      rv[5];
  wr_vec_t      wv[4];
  logic [255:0] rd_exp_q[$];
  wbeat_t       wq[$];
  logic [255:0] rd_e;
  int           checks = 0;
  int           failures = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Read-line scoreboard: every rend_o pulse consumes one expected line.
  always @(negedge clk) begin
    if (rend_o === 1'b1) begin
      if (rd_exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL rend_unexpected actual=1 required=0");
      end else begin
        rd_e = rd_exp_q.pop_front();
        chk("rend_line", line_rdata_o, rd_e);
      end
    end
  end

  task automatic do_read(input rd_vec_t v);
    logic [255:0] exp;
    int n;
    n = int'(v.e_arlen) + 1;
    exp = '0;
    for (int i = 0; i < n; i++) exp[i*32 +: 32] = v.base + 32'(i);
    @(negedge clk);
    ca_rreq_i = v.ca; uc_rreq_i = v.uc; raddr_i = v.addr; uc_size_i = v.size;
    rd_exp_q.push_back(exp);
    @(negedge clk);
    ca_rreq_i = 1'b0; uc_rreq_i = 1'b0; raddr_i = 32'hDEAD_BEE0; uc_size_i = 2'd3;
    chk("arvalid_set", 256'(bus.arvalid), 256'(1'b1));
    chk("araddr", 256'(bus.araddr), 256'(v.e_araddr));
    chk("arlen", 256'(bus.arlen), 256'(v.e_arlen));
    chk("arsize", 256'(bus.arsize), 256'(v.e_arsize));
    chk("arburst_arid", 256'({bus.arburst, bus.arid}), 256'({2'b01, 4'd1}));
    chk("rbusy_set", 256'(rbusy_o), 256'(1'b1));
    chk("rready_in_ar", 256'(bus.rready), 256'(1'b0));
    repeat (v.ar_dly) @(negedge clk);
    chk("arvalid_held", 256'(bus.arvalid), 256'(1'b1));
    bus.arready = 1'b1;
    @(negedge clk);
    bus.arready = 1'b0;
    chk("arvalid_drop", 256'(bus.arvalid), 256'(1'b0));
    chk("rready_set", 256'(bus.rready), 256'(1'b1));
    for (int i = 0; i < n; i++) begin
      bus.rvalid = 1'b1; bus.rdata = v.base + 32'(i); bus.rlast = (i == n - 1);
      bus.rid = 4'hE; bus.rresp = 2'b10;
      @(negedge clk);
    end
    bus.rvalid = 1'b0; bus.rlast = 1'b0; bus.rdata = 32'h0;
    chk("rend_pulse", 256'(rend_o), 256'(1'b1));
    chk("rready_drop", 256'(bus.rready), 256'(1'b0));
    @(negedge clk);
    chk("rend_one_cycle", 256'(rend_o), 256'(1'b0));
    chk("rbusy_clear", 256'(rbusy_o), 256'(1'b0));
    chk("line_held", line_rdata_o, exp);
  endtask

  task automatic do_write(input wr_vec_t v, input logic [31:0] seed);
    logic [255:0] line;
    wbeat_t b, e;
    int cyc;
    for (int i = 0; i < 8; i++) line[i*32 +: 32] = seed + 32'(i) * 32'h0101_0111;
    @(negedge clk);
    wb_req_i = v.wb; uc_wreq_i = v.uc; waddr_i = v.addr; uc_size_i = v.size;
    uc_wdata_i = v.data; uc_wstrb_i = v.strb; wb_line_i = line;
    if (v.wb) begin
      for (int i = 0; i < 8; i++) begin
        b.d = line[i*32 +: 32]; b.s = 4'hF; b.l = (i == 7); wq.push_back(b);
      end
    end else begin
      b.d = v.data; b.s = v.strb; b.l = 1'b1; wq.push_back(b);
    end
    @(negedge clk);
    wb_req_i = 1'b0; uc_wreq_i = 1'b0; waddr_i = 32'hFFFF_FFFF;
    wb_line_i = ~line; uc_wdata_i = ~v.data; uc_wstrb_i = ~v.strb;
    chk("awvalid_set", 256'(bus.awvalid), 256'(1'b1));
    chk("awaddr", 256'(bus.awaddr), 256'(v.e_awaddr));
    chk("awlen", 256'(bus.awlen), 256'(v.e_awlen));
    chk("awsize", 256'(bus.awsize), 256'(v.e_awsize));
    chk("awburst_awid", 256'({bus.awburst, bus.awid}), 256'({2'b01, 4'd1}));
    chk("wbusy_set", 256'(wbusy_o), 256'(1'b1));
    @(negedge clk);
    chk("wvalid_in_aw", 256'(bus.wvalid), 256'(1'b0));
    bus.awready = 1'b1;
    @(negedge clk);
    bus.awready = 1'b0;
    chk("awvalid_drop", 256'(bus.awvalid), 256'(1'b0));
    cyc = 0;
    while (wq.size() > 0 && cyc < 64) begin
      bus.wready = v.toggle ? (cyc % 2 == 1) : 1'b1;
      if (bus.wvalid && bus.wready) begin
        e = wq.pop_front();
        chk("w_beat", 256'({bus.wdata, bus.wstrb, bus.wlast}), 256'({e.d, e.s, e.l}));
      end
      @(negedge clk);
      cyc++;
    end
    bus.wready = 1'b0;
    if (wq.size() != 0) begin
      checks++; failures++;
      $display("FAIL w_beats_timeout actual=%0d required=0", wq.size());
      wq.delete();
    end
    chk("wvalid_drop", 256'(bus.wvalid), 256'(1'b0));
    chk("bready_set", 256'(bus.bready), 256'(1'b1));
    @(negedge clk);
    bus.bvalid = 1'b1; bus.bresp = 2'b11;
    chk("wend_before_b", 256'(wend_o), 256'(1'b0));
    @(negedge clk);
    bus.bvalid = 1'b0; bus.bresp = 2'b00;
    chk("wend_pulse", 256'(wend_o), 256'(1'b1));
    chk("bready_drop", 256'(bus.bready), 256'(1'b0));
    @(negedge clk);
    chk("wend_one_cycle", 256'(wend_o), 256'(1'b0));
    chk("wbusy_clear", 256'(wbusy_o), 256'(1'b0));
  endtask

  initial begin
    rv[0] = '{1'b1, 1'b0, 32'h1F00_0024, 2'd0, 2, 32'd0,        32'h1F00_0020, 8'd7, 3'd2};
    rv[1] = '{1'b0, 1'b1, 32'h8000_1002, 2'd1, 0, 32'h0000_BEEF, 32'h8000_1002, 8'd0, 3'd1};
    rv[2] = '{1'b0, 1'b1, 32'h8000_0003, 2'd0, 1, 32'h0000_005A, 32'h8000_0003, 8'd0, 3'd0};
    rv[3] = '{1'b0, 1'b1, 32'h8000_0104, 2'd2, 3, 32'hCAFE_F00D, 32'h8000_0104, 8'd0, 3'd2};
    rv[4] = '{1'b1, 1'b1, 32'h1234_567C, 2'd1, 1, 32'h5500_0000, 32'h1234_5660, 8'd7, 3'd2};
    wv[0] = '{1'b1, 1'b0, 32'h2000_0047, 2'd0, 32'h0, 4'h0, 1'b1, 32'h2000_0040, 8'd7, 3'd2};
    wv[1] = '{1'b0, 1'b1, 32'h4000_0006, 2'd1, 32'h1234_ABCD, 4'b1100, 1'b0, 32'h4000_0006, 8'd0, 3'd1};
    wv[2] = '{1'b0, 1'b1, 32'h4000_0009, 2'd0, 32'h0000_7700, 4'b0010, 1'b1, 32'h4000_0009, 8'd0, 3'd0};
    wv[3] = '{1'b1, 1'b1, 32'h3000_00FC, 2'd2, 32'h9999_9999, 4'b0001, 1'b0, 32'h3000_00E0, 8'd7, 3'd2};

    rst_n = 1'b0;
    ca_rreq_i = 1'b0; uc_rreq_i = 1'b0; uc_wreq_i = 1'b0; wb_req_i = 1'b0;
    raddr_i = '0; waddr_i = '0; uc_size_i = '0; uc_wdata_i = '0; uc_wstrb_i = '0; wb_line_i = '0;
    bus.arready = 1'b0; bus.rid = '0; bus.rdata = '0; bus.rresp = '0; bus.rlast = 1'b0; bus.rvalid = 1'b0;
    bus.awready = 1'b0; bus.wready = 1'b0; bus.bvalid = 1'b0; bus.bresp = '0;
    repeat (3) @(negedge clk);
    chk("rst_valids", 256'({bus.arvalid, bus.awvalid, bus.wvalid}), 256'(3'b000));
    chk("rst_readys", 256'({bus.rready, bus.bready}), 256'(2'b00));
    chk("rst_pulses", 256'({rend_o, wend_o}), 256'(2'b00));
    chk("rst_busy", 256'({rbusy_o, wbusy_o}), 256'(2'b00));
    chk("rst_line", line_rdata_o, 256'd0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 4; i++) do_read(rv[i]);
    for (int i = 0; i < 3; i++) do_write(wv[i], 32'hC0DE_0000 + 32'(i) * 32'h10);

    // Simultaneous refill+uncached read and writeback+uncached write.
    fork
      do_read(rv[4]);
      do_write(wv[3], 32'hABCD_1000);
    join

    // Reset while beat 3 of a refill is on the bus.
    @(negedge clk);
    ca_rreq_i = 1'b1; raddr_i = 32'h0000_1040;
    @(negedge clk);
    ca_rreq_i = 1'b0;
    bus.arready = 1'b1;
    @(negedge clk);
    bus.arready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.rvalid = 1'b1; bus.rdata = 32'h100 + 32'(i); bus.rlast = 1'b0;
      @(negedge clk);
    end
    bus.rvalid = 1'b1; bus.rdata = 32'h103;
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_rready", 256'(bus.rready), 256'(1'b0));
    chk("mid_rst_busy", 256'({rbusy_o, wbusy_o}), 256'(2'b00));
    chk("mid_rst_line", line_rdata_o, 256'd0);
    chk("mid_rst_valids", 256'({bus.arvalid, bus.awvalid, bus.wvalid, rend_o, wend_o}), 256'(5'd0));
    @(negedge clk);
    bus.rvalid = 1'b0; bus.rdata = 32'h0;
    rst_n = 1'b1;
    @(negedge clk);
    do_read(rv[0]);

    repeat (3) @(negedge clk);
    chk("rd_scoreboard_empty", 256'(rd_exp_q.size()), 256'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
